// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes,
// FSM state encoding and a funct3 legality helper.
package dmem_responder_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Stores accept only B/H/W; loads additionally accept BU/HU
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling: load byte/half select with extension, store
// byte-enables with data replication, and misalignment / funct3 legality.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_c,
  output logic [3:0]  o_be_c,
  output logic [31:0] o_wdata_c,
  output logic        o_misalign_c,
  output logic        o_illegal_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte      = 8'(i_word >> {i_addr_lo, 3'b000});
  assign w_half      = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  assign o_illegal_c = f3_illegal(i_we, i_funct3);

  // Load lane select and sign/zero extension
  always_comb begin
    o_load_c = '0;
    case (i_funct3)
      F3_B:    o_load_c = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_c = {{16{w_half[15]}}, w_half};
      F3_W:    o_load_c = i_word;
      F3_BU:   o_load_c = {24'd0, w_byte};
      F3_HU:   o_load_c = {16'd0, w_half};
      default: o_load_c = '0;
    endcase
  end

  // Store byte-enables and lane-replicated write data
  always_comb begin
    o_be_c    = '0;
    o_wdata_c = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_be_c    = 4'b0001 << i_addr_lo;
        o_wdata_c = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_be_c    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_c = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        o_be_c    = 4'b1111;
        o_wdata_c = i_wdata;
      end
      default: begin
        o_be_c    = '0;
        o_wdata_c = i_wdata;
      end
    endcase
  end

  // Halves need even addresses, words need 4-byte alignment
  always_comb begin
    o_misalign_c = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: o_misalign_c = i_addr_lo[0];
      F3_W:        o_misalign_c = |i_addr_lo;
      default:     o_misalign_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, word store,
// response after LATENCY wait cycles. Optional access counters are built
// when DMEM_STATS_EN is defined.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_commit;
  logic              w_accept;

  logic              r_we;
  logic [31:0]       r_addr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;

  logic [31:0]       r_mem [DEPTH];

  logic [AW-1:0]     w_idx;
  logic              w_oor;
  logic [31:0]       w_word;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_rep;
  logic [31:0]       w_mask;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_err;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign w_accept = (r_state == S_IDLE) && req_valid && r_req_ready;
  assign w_idx    = r_addr[AW+1:2];
  assign w_oor    = (r_addr >> (AW + 2)) != 32'd0;
  assign w_word   = r_mem[w_idx];
  assign w_err    = w_oor || w_misalign || w_illegal;

  dmem_lane_align u_lane_align (
    .i_we         (r_we),
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_word       (w_word),
    .i_wdata      (r_wdata),
    .o_load_c     (w_load),
    .o_be_c       (w_be),
    .o_wdata_c    (w_wdata_rep),
    .o_misalign_c (w_misalign),
    .o_illegal_c  (w_illegal)
  );

  // Expand byte-enables into a bit mask for the read-modify-write merge
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 4; i++) w_mask[8*i +: 8] = {8{w_be[i]}};
  end

  // Next-state, wait countdown and access-commit decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(LATENCY);
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture and registered handshake/response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_funct3 <= req_funct3;
        r_wdata  <= req_wdata;
      end
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
        r_rsp_err   <= w_err;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Store write: only at the commit point, never on error; contents not reset
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      r_mem[w_idx] <= (w_word & ~w_mask) | (w_wdata_rep & w_mask);
    end
  end

`ifdef DMEM_STATS_EN
  logic [31:0] r_stat_loads;
  logic [31:0] r_stat_stores;
  logic [31:0] r_stat_errs;

  assign stat_loads  = r_stat_loads;
  assign stat_stores = r_stat_stores;
  assign stat_errs   = r_stat_errs;

  // Per-completion counters; an errored access counts only as an error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_loads  <= '0;
      r_stat_stores <= '0;
      r_stat_errs   <= '0;
    end else if (w_commit) begin
      if (w_err)     r_stat_errs   <= r_stat_errs + 32'd1;
      else if (r_we) r_stat_stores <= r_stat_stores + 32'd1;
      else           r_stat_loads  <= r_stat_loads + 32'd1;
    end
  end
`endif

endmodule
